// File: rtl/ex_pkg.sv
// Shared operation codes, mul/div FSM state type and iteration count for the execute stage.
package ex_pkg;

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_ADD   = 8'h01;
    localparam logic [7:0] ALU_SUB   = 8'h02;
    localparam logic [7:0] ALU_AND   = 8'h03;
    localparam logic [7:0] ALU_OR    = 8'h04;
    localparam logic [7:0] ALU_XOR   = 8'h05;
    localparam logic [7:0] ALU_NOR   = 8'h06;
    localparam logic [7:0] ALU_SLT   = 8'h07;
    localparam logic [7:0] ALU_SLTU  = 8'h08;
    localparam logic [7:0] ALU_SLL   = 8'h09;
    localparam logic [7:0] ALU_SRL   = 8'h0A;
    localparam logic [7:0] ALU_SRA   = 8'h0B;
    localparam logic [7:0] ALU_LUI   = 8'h0C;
    localparam logic [7:0] MD_MULT   = 8'h10;
    localparam logic [7:0] MD_MULTU  = 8'h11;
    localparam logic [7:0] MD_DIV    = 8'h12;
    localparam logic [7:0] MD_DIVU   = 8'h13;
    localparam logic [7:0] ALU_MFHI  = 8'h14;
    localparam logic [7:0] ALU_MFLO  = 8'h15;
    localparam logic [7:0] ALU_MTHI  = 8'h16;
    localparam logic [7:0] ALU_MTLO  = 8'h17;
    localparam logic [7:0] BR_BEQ    = 8'h20;
    localparam logic [7:0] BR_BNE    = 8'h21;
    localparam logic [7:0] BR_BLEZ   = 8'h22;
    localparam logic [7:0] BR_BGTZ   = 8'h23;
    localparam logic [7:0] BR_BLTZ   = 8'h24;
    localparam logic [7:0] BR_BGEZ   = 8'h25;
    localparam logic [7:0] BR_J      = 8'h26;

    localparam int MD_CYCLES = 32;
    localparam int MD_CNT_W  = $clog2(MD_CYCLES);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// DEC/EX register contents into the execute stage and its results towards EX/MEM and fetch.
interface ex_stage_if #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int ALU_CTLCODE_WIDTH = 8
);
    logic [ADDRESS_WIDTH-1:0]     i_PC;
    logic                         i_Uses_ALU;
    logic [ALU_CTLCODE_WIDTH-1:0] i_ALUCTL;
    logic                         i_Is_Branch;
    logic                         i_prediction;
    logic [ADDRESS_WIDTH-1:0]     i_Branch_Target;
    logic [DATA_WIDTH-1:0]        i_Operand1;
    logic [DATA_WIDTH-1:0]        i_Operand2;
    logic                         i_Writes_Back;
    logic [REG_ADDR_WIDTH-1:0]    i_Write_Addr;
    logic [DATA_WIDTH-1:0]        o_ALU_Result;
    logic                         o_Writes_Back;
    logic [REG_ADDR_WIDTH-1:0]    o_Write_Addr;
    logic                         o_Stall;
    logic                         o_Flush;
    logic [ADDRESS_WIDTH-1:0]     o_Redirect_PC;
    logic                         o_Branch_Resolved;
    logic                         o_Branch_Taken;

    modport master (
        output i_PC, i_Uses_ALU, i_ALUCTL, i_Is_Branch, i_prediction, i_Branch_Target,
               i_Operand1, i_Operand2, i_Writes_Back, i_Write_Addr,
        input  o_ALU_Result, o_Writes_Back, o_Write_Addr, o_Stall, o_Flush,
               o_Redirect_PC, o_Branch_Resolved, o_Branch_Taken
    );

    modport slave (
        input  i_PC, i_Uses_ALU, i_ALUCTL, i_Is_Branch, i_prediction, i_Branch_Target,
               i_Operand1, i_Operand2, i_Writes_Back, i_Write_Addr,
        output o_ALU_Result, o_Writes_Back, o_Write_Addr, o_Stall, o_Flush,
               o_Redirect_PC, o_Branch_Resolved, o_Branch_Taken
    );
endinterface

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) unit owning HI/LO.
// start in IDLE -> 32 BUSY cycles -> one DONE cycle; HI/LO written on the last BUSY edge.
module muldiv_iter
    import ex_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        start_i,
    input  logic        is_div_i,
    input  logic        is_signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        wr_hi_i,
    input  logic        wr_lo_i,
    input  logic [31:0] wr_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div0_q, div0_d;
    logic [31:0]         a_q, a_d, acc_q, acc_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;

    logic        sa, sb, div_ge;
    logic [32:0] mul_sum, div_rs;
    logic [31:0] step_acc, step_sh;
    logic [63:0] prod, prod_fix;

    assign sa = is_signed_i & opa_i[31];
    assign sb = is_signed_i & opb_i[31];

    // Multiply keeps {acc,sh} as a 64-bit shift register; divide keeps remainder in acc, quotient in sh.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + {1'b0, (sh_q[0] ? a_q : 32'd0)};
        div_rs   = {acc_q, sh_q[31]};
        div_ge   = (div_rs >= {1'b0, a_q});
        step_acc = is_div_q ? (div_ge ? (div_rs[31:0] - a_q) : div_rs[31:0]) : mul_sum[32:1];
        step_sh  = is_div_q ? {sh_q[30:0], div_ge} : {mul_sum[0], sh_q[31:1]};
        prod     = {step_acc, step_sh};
        prod_fix = neg_lo_q ? (64'd0 - prod) : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        a_d      = a_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (wr_hi_i) hi_d = wr_dat_i;
        if (wr_lo_i) lo_d = wr_dat_i;
        case (state_q)
            MD_IDLE: if (start_i) begin
                is_div_d = is_div_i;
                neg_lo_d = sa ^ sb;
                neg_hi_d = is_div_i ? sa : (sa ^ sb);
                div0_d   = is_div_i & (opb_i == '0);
                a_d      = sb ? (32'd0 - opb_i) : opb_i;
                sh_d     = sa ? (32'd0 - opa_i) : opa_i;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = MD_BUSY;
            end
            MD_BUSY: begin
                acc_d = step_acc;
                sh_d  = step_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MD_CNT_W'(MD_CYCLES - 1)) begin
                    state_d = MD_DONE;
                    if (is_div_q) begin
                        // Divide by zero leaves the dividend in the remainder; only LO needs forcing.
                        lo_d = div0_q ? 32'hFFFF_FFFF : (neg_lo_q ? (32'd0 - step_sh) : step_sh);
                        hi_d = neg_hi_q ? (32'd0 - step_acc) : step_acc;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign done_o = (state_q == MD_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU and branch resolution plus the iterative mul/div unit.
// Results are combinational; o_Stall holds upstream for issue + 32 cycles of a mul/div.
module ex_stage
    import ex_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int ALU_CTLCODE_WIDTH = 8
)(
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    ex_stage_if.slave  bus
);
    logic                  is_md, is_mt, md_start, md_busy, md_done, stall;
    logic                  taken, resolved;
    logic [31:0]           hi, lo;
    logic [DATA_WIDTH-1:0] op1, op2, alu_res;
    logic [4:0]            shamt;

    assign op1   = bus.i_Operand1;
    assign op2   = bus.i_Operand2;
    assign shamt = op1[4:0];
    assign is_md = bus.i_ALUCTL inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    assign is_mt = bus.i_ALUCTL inside {ALU_MTHI, ALU_MTLO};

    // Reset gates issue so a held mul/div in DEC/EX cannot keep o_Stall high during reset.
    assign md_start = i_Reset_n & bus.i_Uses_ALU & is_md & ~md_busy & ~md_done;
    assign stall    = md_start | md_busy;

    muldiv_iter u_muldiv (
        .i_Clk       (i_Clk),
        .i_Reset_n   (i_Reset_n),
        .start_i     (md_start),
        .is_div_i    (bus.i_ALUCTL inside {MD_DIV, MD_DIVU}),
        .is_signed_i (bus.i_ALUCTL inside {MD_MULT, MD_DIV}),
        .opa_i       (op1[31:0]),
        .opb_i       (op2[31:0]),
        .wr_hi_i     (bus.i_Uses_ALU & ~stall & (bus.i_ALUCTL == ALU_MTHI)),
        .wr_lo_i     (bus.i_Uses_ALU & ~stall & (bus.i_ALUCTL == ALU_MTLO)),
        .wr_dat_i    (op1[31:0]),
        .busy_o      (md_busy),
        .done_o      (md_done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always_comb begin
        alu_res = '0;
        case (bus.i_ALUCTL)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_NOR:  alu_res = ~(op1 | op2);
            ALU_SLT:  alu_res = DATA_WIDTH'($signed(op1) < $signed(op2));
            ALU_SLTU: alu_res = DATA_WIDTH'(op1 < op2);
            ALU_SLL:  alu_res = op2 << shamt;
            ALU_SRL:  alu_res = op2 >> shamt;
            ALU_SRA:  alu_res = $signed(op2) >>> shamt;
            ALU_LUI:  alu_res = op2 << 16;
            ALU_MFHI: alu_res = DATA_WIDTH'(hi);
            ALU_MFLO: alu_res = DATA_WIDTH'(lo);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (bus.i_ALUCTL)
            BR_BEQ:  taken = (op1 == op2);
            BR_BNE:  taken = (op1 != op2);
            BR_BLEZ: taken = ($signed(op1) <= 0);
            BR_BGTZ: taken = ($signed(op1) > 0);
            BR_BLTZ: taken = ($signed(op1) < 0);
            BR_BGEZ: taken = ($signed(op1) >= 0);
            BR_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign resolved              = bus.i_Is_Branch & bus.i_Uses_ALU;
    assign bus.o_Branch_Resolved = resolved;
    assign bus.o_Branch_Taken    = resolved & taken;
    assign bus.o_Flush           = resolved & (taken != bus.i_prediction) & ~stall;
    assign bus.o_Redirect_PC     = resolved ? (taken ? bus.i_Branch_Target
                                                     : bus.i_PC + ADDRESS_WIDTH'(4))
                                            : '0;
    assign bus.o_ALU_Result      = alu_res;
    assign bus.o_Writes_Back     = bus.i_Writes_Back & bus.i_Uses_ALU & ~stall & ~is_md & ~is_mt;
    assign bus.o_Write_Addr      = bus.i_Write_Addr;
    assign bus.o_Stall           = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a plain-arithmetic reference of ALU, branch and HI/LO behaviour.
`timescale 1ns/1ps
module tb_ex_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_stage_if bus ();
    ex_stage dut (.i_Clk(clk), .i_Reset_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sb;
        sb = longint'(int'(b));
        case (code)
            8'h01: return a + b;
            8'h02: return a - b;
            8'h03: return a & b;
            8'h04: return a | b;
            8'h05: return a ^ b;
            8'h06: return ~(a | b);
            8'h07: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            8'h08: return (a < b) ? 32'd1 : 32'd0;
            8'h09: return 32'(64'(b) * (64'd1 << a[4:0]));
            8'h0A: return 32'(64'(b) / (64'd1 << a[4:0]));
            8'h0B: return 32'((sb - ((sb % (longint'(1) << a[4:0]) + (longint'(1) << a[4:0])) % (longint'(1) << a[4:0]))) / (longint'(1) << a[4:0]));
            8'h0C: return {b[15:0], 16'h0};
            8'h14: return m_hi;
            8'h15: return m_lo;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic br_model(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            8'h20: return a == b;
            8'h21: return a != b;
            8'h22: return int'(a) <= 0;
            8'h23: return int'(a) > 0;
            8'h24: return int'(a) < 0;
            8'h25: return int'(a) >= 0;
            8'h26: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic md_model(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, p;
        logic [63:0] up;
        sa  = longint'(int'(a));
        sbv = longint'(int'(b));
        case (code)
            8'h10: begin p = sa * sbv; {m_hi, m_lo} = 64'(p); end
            8'h11: begin up = 64'(a) * 64'(b); {m_hi, m_lo} = up; end
            8'h12: if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
                   else begin m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv); end
            default: if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                     else begin m_lo = a / b; m_hi = a % b; end
        endcase
    endtask

    task automatic drive(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.i_ALUCTL        = code;
        bus.i_Operand1      = a;
        bus.i_Operand2      = b;
        bus.i_Uses_ALU      = 1'b1;
        bus.i_Writes_Back   = 1'b1;
        bus.i_Is_Branch     = 1'b0;
        bus.i_prediction    = 1'b0;
        bus.i_PC            = {$urandom_range(0, 65535), 2'b00};
        bus.i_Branch_Target = {$urandom_range(0, 65535), 2'b00};
        bus.i_Write_Addr    = 5'($urandom_range(1, 31));
    endtask

    task automatic drive_zero();
        bus.i_ALUCTL = '0; bus.i_Operand1 = '0; bus.i_Operand2 = '0; bus.i_Uses_ALU = 1'b0;
        bus.i_Writes_Back = 1'b0; bus.i_Is_Branch = 1'b0; bus.i_prediction = 1'b0;
        bus.i_PC = '0; bus.i_Branch_Target = '0; bus.i_Write_Addr = '0;
    endtask

    task automatic check_hilo(input string tag);
        @(posedge clk); #1; drive(8'h14, $urandom, $urandom);
        @(negedge clk);
        checks++;
        if (bus.o_ALU_Result !== m_hi) begin errors++; $display("FAIL %s_mfhi: got %h expected %h", tag, bus.o_ALU_Result, m_hi); end
        @(posedge clk); #1; drive(8'h15, $urandom, $urandom);
        @(negedge clk);
        checks++;
        if (bus.o_ALU_Result !== m_lo) begin errors++; $display("FAIL %s_mflo: got %h expected %h", tag, bus.o_ALU_Result, m_lo); end
    endtask

    task automatic run_md(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk); #1; drive(code, a, b);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_Stall !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL md_stall_len op=%h: got %0d cycles expected 33", code, n); end
        checks++;
        if ({bus.o_Stall, bus.o_Writes_Back} !== 2'b00) begin
            errors++; $display("FAIL md_retire op=%h: got stall/wb %b expected 00", code, {bus.o_Stall, bus.o_Writes_Back});
        end
        md_model(code, a, b);
    endtask

    task automatic test_reset();
        drive_zero();
        #12;
        checks++;
        if (bus.o_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall_in_reset: got %b expected 0", bus.o_Stall); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Write_Addr, bus.o_Stall, bus.o_Flush,
             bus.o_Redirect_PC, bus.o_Branch_Resolved, bus.o_Branch_Taken} !== '0) begin
            errors++; $display("FAIL reset_outputs: got res=%h wb=%b stall=%b flush=%b rpc=%h expected all 0",
                               bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Stall, bus.o_Flush, bus.o_Redirect_PC);
        end
        check_hilo("reset");
    endtask

    task automatic test_alu_directed();
        logic [7:0]  codes [3] = '{8'h01, 8'h07, 8'h08};
        logic [31:0] op1s  [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] op2s  [3] = '{32'h1, 32'h1, 32'h1};
        logic [31:0] exps  [3] = '{32'h8000_0000, 32'h1, 32'h0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; drive(codes[i], op1s[i], op2s[i]);
            @(negedge clk);
            checks++;
            if ({bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Stall} !== {exps[i], 2'b10}) begin
                errors++; $display("FAIL alu_directed op=%h: got res=%h wb=%b stall=%b expected res=%h wb=1 stall=0",
                                   codes[i], bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Stall, exps[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [7:0] codes [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                                   8'h0A, 8'h0B, 8'h0C, 8'h14, 8'h15, 8'h0D, 8'h0F, 8'h18, 8'h30, 8'hFF};
        logic [7:0]  c;
        logic [31:0] a, b, exp_r;
        logic        uses, wb;
        for (int i = 0; i < 200; i++) begin
            c = codes[$urandom_range(0, 19)];
            a = rnd_op(); b = rnd_op();
            uses = ($urandom_range(0, 7) != 0);
            wb   = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1; drive(c, a, b);
            bus.i_Uses_ALU = uses; bus.i_Writes_Back = wb;
            exp_r = alu_model(c, a, b);
            @(negedge clk);
            checks++;
            if (uses && bus.o_ALU_Result !== exp_r) begin
                errors++; $display("FAIL alu_rand op=%h a=%h b=%h: got %h expected %h", c, a, b, bus.o_ALU_Result, exp_r);
            end
            checks++;
            if ({bus.o_Writes_Back, bus.o_Write_Addr, bus.o_Branch_Resolved, bus.o_Flush} !== {uses & wb, bus.i_Write_Addr, 2'b00}) begin
                errors++; $display("FAIL alu_ctl op=%h: got wb=%b wa=%0d res=%b fl=%b expected wb=%b wa=%0d",
                                   c, bus.o_Writes_Back, bus.o_Write_Addr, bus.o_Branch_Resolved, bus.o_Flush, uses & wb, bus.i_Write_Addr);
            end
        end
    endtask

    task automatic test_branch();
        logic [7:0]  c;
        logic [31:0] a, b, pc, tgt, exp_pc;
        logic        pred, uses, t;
        for (int i = 0; i < 160; i++) begin
            if (i < 3) begin
                c = (i == 1) ? 8'h21 : 8'h20; a = 4; b = 4; pc = 32'h100; tgt = 32'h200;
                pred = (i != 0); uses = 1'b1;
            end else begin
                c = 8'($urandom_range(8'h20, 8'h26)); a = rnd_op();
                b = ($urandom_range(0, 2) == 0) ? a : rnd_op();
                pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                pred = 1'($urandom_range(0, 1)); uses = ($urandom_range(0, 7) != 0);
            end
            @(posedge clk); #1; drive(c, a, b);
            bus.i_Is_Branch = 1'b1; bus.i_prediction = pred; bus.i_PC = pc;
            bus.i_Branch_Target = tgt; bus.i_Uses_ALU = uses;
            t = br_model(c, a, b);
            exp_pc = !uses ? 32'h0 : (t ? tgt : pc + 32'd4);
            @(negedge clk);
            checks++;
            if ({bus.o_Branch_Resolved, bus.o_Branch_Taken, bus.o_Flush, bus.o_Stall} !== {uses, uses & t, uses & (t != pred), 1'b0}) begin
                errors++; $display("FAIL branch_ctl op=%h a=%h b=%h pred=%b: got res/tk/fl/st=%b%b%b%b expected %b%b%b0",
                                   c, a, b, pred, bus.o_Branch_Resolved, bus.o_Branch_Taken, bus.o_Flush, bus.o_Stall,
                                   uses, uses & t, uses & (t != pred));
            end
            checks++;
            if (bus.o_Redirect_PC !== exp_pc) begin
                errors++; $display("FAIL branch_pc op=%h: got %h expected %h", c, bus.o_Redirect_PC, exp_pc);
            end
        end
        @(posedge clk); #1; drive(8'h01, 32'd3, 32'd4);
        @(negedge clk);
        checks++;
        if ({bus.o_Flush, bus.o_Redirect_PC, bus.o_Branch_Resolved} !== '0) begin
            errors++; $display("FAIL branch_nonbranch: got fl=%b pc=%h res=%b expected 0", bus.o_Flush, bus.o_Redirect_PC, bus.o_Branch_Resolved);
        end
    endtask

    task automatic test_mt();
        logic [31:0] v;
        @(posedge clk); #1; drive(8'h16, 32'h1234, $urandom);
        m_hi = 32'h1234;
        @(negedge clk);
        checks++;
        if ({bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Stall} !== 34'h0) begin
            errors++; $display("FAIL mthi_cycle: got res=%h wb=%b stall=%b expected 0", bus.o_ALU_Result, bus.o_Writes_Back, bus.o_Stall);
        end
        v = $urandom;
        @(posedge clk); #1; drive(8'h17, v, $urandom);
        m_lo = v;
        check_hilo("mt");
    endtask

    task automatic test_muldiv();
        logic [7:0]  dcodes [6] = '{8'h10, 8'h12, 8'h13, 8'h12, 8'h12, 8'h11};
        logic [31:0] das    [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        logic [31:0] dbs    [6] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [7:0]  c;
        for (int i = 0; i < 6; i++) begin
            run_md(dcodes[i], das[i], dbs[i]);
            check_hilo("md_directed");
        end
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(8'h10, 8'h13));
            run_md(c, rnd_op(), rnd_op());
            check_hilo("md_random");
        end
    endtask

    task automatic test_back_to_back();
        run_md(8'h10, 32'd123456, 32'hFFFF_FF00);
        run_md(8'h10, $urandom, $urandom);
        @(posedge clk); #1; drive_zero();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_Stall !== 1'b0) begin errors++; $display("FAIL b2b_no_reissue cycle %0d: got stall %b expected 0", i, bus.o_Stall); end
        end
        check_hilo("b2b");
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1; drive(8'h13, 32'd1000, 32'd7);
        @(negedge clk);
        checks++;
        if (bus.o_Stall !== 1'b1) begin errors++; $display("FAIL rst_busy_issue: got stall %b expected 1", bus.o_Stall); end
        repeat (11) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_Stall !== 1'b0) begin errors++; $display("FAIL rst_busy_stall: got stall %b expected 0", bus.o_Stall); end
        drive_zero();
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1; rst_n = 1'b1;
        check_hilo("rst_busy");
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_branch();
        test_mt();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipeline.
- Consumes the registered outputs of the decode/execute pipeline register and computes the ALU result.
- Resolves branches against the fetch-time prediction and raises flush/redirect on a mispredict.
- Holds an iterative 32-cycle multiply/divide unit with HI/LO registers. While that unit is busy, it stalls the upstream pipeline.
- Results feed the execute/memory pipeline register combinationally.

Parameters:
ADDRESS_WIDTH, 32, PC/target width
DATA_WIDTH, 32, operand/result width (mul/div is fixed at 32)
REG_ADDR_WIDTH, 5, destination register index width
ALU_CTLCODE_WIDTH, 8, ALU control code width

Ports:
i_Clk  in  1  clock
i_Reset_n  in  1  async active-low reset
i_PC  in  ADDRESS_WIDTH  PC of instruction in EX
i_Uses_ALU  in  1  instruction valid for ALU/muldiv
i_ALUCTL  in  ALU_CTLCODE_WIDTH  operation code
i_Is_Branch  in  1  instruction is branch/jump
i_prediction  in  1  fetch predicted taken
i_Branch_Target  in  ADDRESS_WIDTH  taken target
i_Operand1  in  DATA_WIDTH  rs value / shift amount
i_Operand2  in  DATA_WIDTH  rt value / immediate
i_Writes_Back  in  1  decoder writeback flag
i_Write_Addr  in  REG_ADDR_WIDTH  destination register
o_ALU_Result  out  DATA_WIDTH  result
o_Writes_Back  out  1  qualified writeback
o_Write_Addr  out  REG_ADDR_WIDTH  pass-through
o_Stall  out  1  hold PC, IF/DEC, DEC/EX; bubble EX/MEM
o_Flush  out  1  mispredict, flush younger stages
o_Redirect_PC  out  ADDRESS_WIDTH  correct next PC
o_Branch_Resolved  out  1  predictor update strobe
o_Branch_Taken  out  1  actual outcome

Behaviour:
- Clock i_Clk; reset i_Reset_n asynchronous, active-low.
- Reset state:
  - HI=0, LO=0.
  - FSM=IDLE, counter=0.
  - o_Stall=0.
- All other outputs are combinational from inputs and state. With the all-zero DEC/EX input present after reset, every output is 0.
- ALU codes (combinational, same cycle):
  - NOP 0x00: result 0.
  - ADD 0x01 / SUB 0x02: wrap mod 2^32, no overflow trap.
  - AND 0x03, OR 0x04, XOR 0x05, NOR 0x06.
  - SLT 0x07 (signed) / SLTU 0x08: result 1 or 0.
  - SLL 0x09, SRL 0x0A, SRA 0x0B: Operand2 shifted by Operand1[4:0].
  - LUI 0x0C: Operand2<<16.
  - MFHI 0x14 / MFLO 0x15: result HI / LO.
  - MTHI 0x16 / MTLO 0x17: write Operand1 to HI / LO at clock edge; result 0.
  - Undefined codes: result 0.
- Branch codes, compared on Operand1 vs Operand2 / zero:
  - BEQ 0x20, BNE 0x21, BLEZ 0x22, BGTZ 0x23, BLTZ 0x24, BGEZ 0x25.
  - J 0x26: always taken.
- Branch resolution, when i_Is_Branch & i_Uses_ALU:
  - o_Branch_Resolved=1 and o_Branch_Taken=actual outcome.
  - o_Flush=1 iff taken != i_prediction.
  - o_Redirect_PC = taken ? i_Branch_Target : i_PC+4 (no delay slot).
  - Otherwise o_Flush=0, o_Redirect_PC=0, o_Branch_Resolved=0.
- o_Writes_Back = i_Writes_Back & i_Uses_ALU & ~o_Stall. It is forced 0 for MULT/DIV/MTHI/MTLO.
- Mul/div codes: MULT 0x10, MULTU 0x11, DIV 0x12, DIVU 0x13.
- FSM states IDLE, BUSY, DONE:
  - IDLE:
    - On a mul/div code with i_Uses_ALU: latch operand magnitudes and sign flags, counter=0, go to BUSY. o_Stall=1 in this issue cycle.
  - BUSY:
    - o_Stall=1.
    - Each cycle performs one shift-add (multiply) or one restoring subtract step (divide); counter++.
    - At counter==31: sign-correct, write HI/LO, go to DONE.
  - DONE:
    - o_Stall=0, so the instruction retires; go to IDLE.
    - The held mul/div code is not re-issued.
- Stall timing: o_Stall is high for exactly 33 consecutive cycles (issue + 32 BUSY).
- Result conventions:
  - MULT: signed 64-bit product, {HI,LO}.
  - DIV: quotient truncates toward zero into LO; remainder takes the sign of the dividend, into HI.
  - Divide by zero (either signedness): LO=0xFFFFFFFF, HI=dividend; no trap.
  - DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- Simultaneity:
  - An MTHI/MTLO in DONE cannot occur; only one instruction occupies EX.
  - o_Flush never asserts while o_Stall=1.
- Reset mid-BUSY: FSM goes to IDLE, HI/LO are cleared, o_Stall drops immediately, and the partial result is discarded.

Decomposition:
- Package ex_pkg: ALU/branch/muldiv code constants, FSM state enum, and the 32-cycle count constant.
- Sub-module muldiv_iter:
  - Owns FSM, counter, HI/LO.
  - Handshake: start in; busy/done out; HI/LO out; MTHI/MTLO write ports in.
- ex_stage holds the combinational ALU and branch logic.

Test Plan:
- ADD 0x7FFFFFFF+1 -> result 0x80000000, o_Writes_Back=1, no stall. SLT 0xFFFFFFFF,1 -> 1. SLTU same -> 0.
- MULT -3*7 -> o_Stall high 33 cycles; then MFLO=0xFFFFFFEB, MFHI=0xFFFFFFFF.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- BEQ 4,4 with prediction 0, PC 0x100, target 0x200 -> o_Flush=1, redirect 0x200. BNE 4,4 with prediction 1 -> o_Flush=1, redirect 0x104. Correct prediction -> o_Flush=0, o_Branch_Resolved=1.
- Assert reset on BUSY cycle 10 of DIVU -> o_Stall=0 immediately; then MFHI=0 and MFLO=0.
- MTHI 0x1234 then MFHI -> 0x1234. A MULT followed back-to-back by a second MULT -> each stalls 33 cycles with a single retire per instruction.
